// File: rtl/i2c_reg_master.sv
// ---------------------------------------------------------------------------
// i2c_reg_master
//
// Single-register I2C master. A one-cycle req in IDLE launches either a
// register write   : S, {dev,0}, reg, wdata, P
// or a register read : S, {dev,0}, reg, Sr, {dev,1}, data, NACK, P
// A missing ACK in any ACK slot aborts straight to STOP with nack=1.
// Both bus lines are open-drain: *_oe=1 pulls the line low, *_oe=0 releases.
//
// Bit timing: every bit is four quarters of (CLK_DIV+1) clk cycles.
//   q0 SCL low, SDA updated | q1..q3 SCL released | SDA sampled at end of q2
//
// Build option: define I2C_MASTER_CLK_STRETCH_EN to synchronise scl_i and
// hold the quarter counter while a released SCL is still read low (target
// clock stretching). Without it scl_i is ignored and timing is counter-only.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   req, rw             start strobe (IDLE only), 0=write 1=read
//   dev_addr, reg_addr  7-bit target address, register address
//   wdata               write data
//   busy, done, nack    in-progress, 1-cycle completion, aborted on NACK
//   rdata               read data, held until next accepted request
//   scl_oe, sda_oe      open-drain pull-down enables
//   scl_i, sda_i        pin levels
//
// state   | meaning
// IDLE    | bus released, waiting for req
// START   | SDA low with SCL released for one half-bit
// TX_BYTE | shifting out the current byte, MSB first
// RX_ACK  | SDA released, sampling the target's ACK
// RX_BYTE | SDA released, shifting in read data
// TX_NACK | master NACK after the read byte
// RSTART  | repeated START between register address and read address
// STOP    | SDA low, SCL released, then SDA released
// DONE    | one-cycle completion pulse
// ---------------------------------------------------------------------------
module i2c_reg_master #(
    parameter int unsigned CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int QW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        RX_BYTE,
        TX_NACK,
        RSTART,
        STOP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [2:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          nack_q, nack_d;

    logic          stall;
    logic          run;
    logic          tick;
    logic [7:0]    cur_byte;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    logic [1:0] scl_sync_q;

    // Reset to released-high so an idle bus never looks stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
        end
    end

    // Counter freezes whenever we have released SCL but it still reads low.
    assign stall = (state_q != IDLE) && !scl_oe && !scl_sync_q[1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign run  = (state_q != IDLE) && (state_q != DONE) && !stall;
    assign tick = run && (qcnt_q == QMAX);

    // Byte slot 2 is the read address on reads and the data byte on writes.
    always_comb begin
        cur_byte = {dev_q, 1'b0};
        case (byte_q)
            2'd1:    cur_byte = reg_q;
            2'd2:    cur_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
            default: cur_byte = {dev_q, 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;

        if (run) begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
        end
        if (tick) begin
            qtr_d = qtr_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    dev_d   = dev_addr;
                    reg_d   = reg_addr;
                    wdata_d = wdata;
                    nack_d  = 1'b0;
                    qcnt_d  = '0;
                    qtr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick && qtr_q == 3'd1) begin
                    qtr_d   = '0;
                    state_d = TX_BYTE;
                end
            end
            TX_BYTE: begin
                if (tick && qtr_q == 3'd3) begin
                    qtr_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_ACK;
                    end
                end
            end
            RX_ACK: begin
                if (tick && qtr_q == 3'd2) begin
                    nack_d = sda_i;
                end
                if (tick && qtr_q == 3'd3) begin
                    qtr_d = '0;
                    if (nack_q) begin
                        state_d = STOP;
                    end else if (byte_q == 2'd0) begin
                        byte_d  = 2'd1;
                        state_d = TX_BYTE;
                    end else if (byte_q == 2'd1) begin
                        if (rw_q) begin
                            state_d = RSTART;
                        end else begin
                            byte_d  = 2'd2;
                            state_d = TX_BYTE;
                        end
                    end else if (rw_q) begin
                        state_d = RX_BYTE;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            RX_BYTE: begin
                if (tick && qtr_q == 3'd2) begin
                    rx_d = {rx_q[6:0], sda_i};
                end
                if (tick && qtr_q == 3'd3) begin
                    qtr_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        // rx_q already holds the last bit sampled in q2.
                        rdata_d = rx_q;
                        state_d = TX_NACK;
                    end
                end
            end
            TX_NACK: begin
                if (tick && qtr_q == 3'd3) begin
                    qtr_d   = '0;
                    state_d = STOP;
                end
            end
            RSTART: begin
                if (tick && qtr_q == 3'd3) begin
                    qtr_d   = '0;
                    byte_d  = 2'd2;
                    state_d = TX_BYTE;
                end
            end
            STOP: begin
                // q0 SCL low, q1-q2 SCL high with SDA low, q3-q4 both released.
                if (tick && qtr_q == 3'd4) begin
                    qtr_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            START: begin
                sda_oe = 1'b1;
            end
            TX_BYTE: begin
                scl_oe = (qtr_q == 3'd0);
                sda_oe = ~cur_byte[3'd7 - bit_q];
            end
            RX_ACK, RX_BYTE, TX_NACK: begin
                scl_oe = (qtr_q == 3'd0);
            end
            RSTART: begin
                scl_oe = (qtr_q == 3'd0);
                sda_oe = (qtr_q >= 3'd2);
            end
            STOP: begin
                scl_oe = (qtr_q == 3'd0);
                sda_oe = (qtr_q <= 3'd2);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign nack  = nack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
`timescale 1ns/1ps
module tb_i2c_reg_master;

    localparam int         CLK_DIV = 3;
    localparam logic [6:0] SLV     = 7'h42;
    localparam int         TK_S    = 'h1000;
    localparam int         TK_P    = 'h2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, nack;
    logic [7:0] rdata;
    logic       scl_oe, sda_oe, scl_i, sda_i;
    logic       slv_pull = 1'b0;
    logic       slv_hold = 1'b0;

    assign scl_i = ~(scl_oe | slv_hold);
    assign sda_i = ~(sda_oe | slv_pull);

    always #5 clk = ~clk;

    i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .nack(nack),
        .rdata(rdata), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected transaction: bus token list plus status at done.
    typedef struct packed {
        logic [7:0][13:0] tok;
        logic [3:0]       n;
        logic             nack;
        logic [7:0]       rdata;
    } exp_t;

    exp_t       sb_q[$];
    int         obs_q[$];
    logic [7:0] mem_m   [256];
    logic [7:0] slv_mem [256];
    logic [7:0] last_rdata = 8'h00;

    function automatic logic [13:0] tk(logic [7:0] b, logic ack_bit);
        return {5'b0, b, ack_bit};
    endfunction

    // Reference: the bus sequence a register access must produce.
    function automatic exp_t model(logic r, logic [6:0] d, logic [7:0] ra, logic [7:0] wd);
        exp_t e;
        e = '0;
        e.tok[0] = TK_S[13:0];
        if (d != SLV) begin
            e.tok[1] = tk({d, 1'b0}, 1'b1);
            e.tok[2] = TK_P[13:0];
            e.n      = 4'd3;
            e.nack   = 1'b1;
        end else if (!r) begin
            e.tok[1] = tk({d, 1'b0}, 1'b0);
            e.tok[2] = tk(ra, 1'b0);
            e.tok[3] = tk(wd, 1'b0);
            e.tok[4] = TK_P[13:0];
            e.n      = 4'd5;
            mem_m[ra] = wd;
        end else begin
            e.tok[1] = tk({d, 1'b0}, 1'b0);
            e.tok[2] = tk(ra, 1'b0);
            e.tok[3] = TK_S[13:0];
            e.tok[4] = tk({d, 1'b1}, 1'b0);
            e.tok[5] = tk(mem_m[ra], 1'b1);
            e.tok[6] = TK_P[13:0];
            e.n      = 4'd7;
            last_rdata = mem_m[ra];
        end
        e.rdata = last_rdata;
        return e;
    endfunction

    // Bus monitor, target model and scoreboard checker share one process so
    // the monitor always observes the bus before the target reacts to it.
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         mbits = 0;
    logic [8:0] msh = '0;
    int         n_done = 0;
    bit         after_done = 1'b0;
    int         low_run = 0, max_low = 0;
    exp_t       mon_e;
    int         s_cnt = 0, s_byte = 0, hold_cnt = 0;
    bit         s_adr = 0, s_rd = 0, s_tx = 0, s_go = 0, stretch_on = 0;
    logic [7:0] s_sh = '0, s_ptr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            obs_q.delete();
            mbits = 0; after_done = 0; low_run = 0;
            s_cnt = 0; s_byte = 0; s_tx = 0; s_go = 0; s_adr = 0;
            hold_cnt = 0; slv_pull = 1'b0; slv_hold = 1'b0;
            scl_p = 1'b1; sda_p = 1'b1;
        end else begin
            if (after_done) begin
                check("busy_after_done", busy, 0);
                check("done_one_cycle", done, 0);
                after_done = 0;
            end
            if (scl_p && scl_i && sda_p && !sda_i) begin
                obs_q.push_back(TK_S); mbits = 0;
            end else if (scl_p && scl_i && !sda_p && sda_i) begin
                obs_q.push_back(TK_P); mbits = 0;
            end else if (!scl_p && scl_i) begin
                msh = {msh[7:0], sda_i};
                mbits++;
                if (mbits == 9) begin
                    obs_q.push_back(int'(msh)); mbits = 0;
                end
            end
            low_run = scl_i ? 0 : low_run + 1;
            if (low_run > max_low) max_low = low_run;

            if (done) begin
                check("pending_at_done", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("tok_count", obs_q.size(), int'(mon_e.n));
                    for (int i = 0; i < int'(mon_e.n) && i < obs_q.size(); i++)
                        check($sformatf("tok%0d", i), obs_q[i], int'(mon_e.tok[i]));
                    check("nack", nack, mon_e.nack);
                    check("rdata", rdata, mon_e.rdata);
                end
                obs_q.delete();
                after_done = 1;
                n_done++;
            end

            // Target at address SLV with a 256-byte register file.
            if (hold_cnt > 0) hold_cnt--;
            if (scl_p && scl_i && sda_p && !sda_i) begin
                s_cnt = 0; s_byte = 0; s_tx = 0; s_go = 0; slv_pull = 1'b0;
            end else if (scl_p && scl_i && !sda_p && sda_i) begin
                s_cnt = 0; s_tx = 0; s_go = 0; s_adr = 0; slv_pull = 1'b0;
            end else if (!scl_p && scl_i) begin
                s_sh = {s_sh[6:0], sda_i};
                s_cnt++;
            end else if (scl_p && !scl_i && s_cnt > 0) begin
                if (s_cnt == 8) begin
                    if (s_tx) slv_pull = 1'b0;
                    else begin
                        if (s_byte == 0) begin
                            s_adr = (s_sh[7:1] == SLV);
                            s_rd  = s_sh[0];
                            s_go  = s_adr && s_sh[0];
                        end else if (s_byte == 1 && s_adr && !s_rd) s_ptr = s_sh;
                        else if (s_byte == 2 && s_adr && !s_rd) slv_mem[s_ptr] = s_sh;
                        slv_pull = s_adr;
                    end
                end else if (s_cnt == 9) begin
                    s_cnt = 0; s_byte++; slv_pull = 1'b0;
                    if (stretch_on) hold_cnt = 40;
                    if (s_go) begin
                        s_go = 0; s_tx = 1; slv_pull = ~slv_mem[s_ptr][7];
                    end else s_tx = 0;
                end else if (s_tx) slv_pull = ~slv_mem[s_ptr][7 - s_cnt];
            end
            slv_hold = (hold_cnt > 0);
            scl_p = scl_i;
            sda_p = sda_i;
        end
    end

    task automatic issue(logic r, logic [6:0] d, logic [7:0] ra, logic [7:0] wd, bit push);
        @(negedge clk);
        if (push) sb_q.push_back(model(r, d, ra, wd));
        rw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        check("busy_on_accept", busy, 1);
        check("nack_cleared", nack, 0);
        req = 1'b0;
    endtask

    task automatic wait_done(int d0);
        int k;
        k = 0;
        while (n_done == d0 && k < 5000) begin
            @(negedge clk); k++;
        end
        check("done_in_time", int'(n_done != d0), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic txn(logic r, logic [6:0] d, logic [7:0] ra, logic [7:0] wd);
        int d0;
        d0 = n_done;
        issue(r, d, ra, wd, 1'b1);
        wait_done(d0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0, k;
        bit  bsy;
        logic [6:0] d;
        logic       r;

        for (int i = 0; i < 256; i++) begin
            mem_m[i]   = 8'($urandom);
            slv_mem[i] = mem_m[i];
        end
        mem_m[3] = 8'h3C; slv_mem[3] = 8'h3C;

        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        txn(1'b0, SLV, 8'h05, 8'hA5);
        txn(1'b1, SLV, 8'h03, 8'h00);
        txn(1'b0, 7'h11, 8'h07, 8'h99);
        txn(1'b1, 7'h11, 8'h03, 8'h00);

        // Second req while busy must be ignored.
        d0 = n_done;
        issue(1'b0, SLV, 8'h10, 8'h6B, 1'b1);
        repeat (100) @(negedge clk);
        rw = 1'b1; reg_addr = 8'hEE; wdata = 8'h00; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(d0);
        bsy = 0;
        repeat (200) begin
            @(negedge clk); bsy |= busy;
        end
        check("req_ignored_busy", bsy, 0);
        txn(1'b1, SLV, 8'h10, 8'h00);

        // Reset in the middle of the data byte.
        issue(1'b0, SLV, 8'h20, 8'h5A, 1'b0);
        k = 0;
        while (obs_q.size() < 3 && k < 2000) begin
            @(negedge clk); k++;
        end
        check("reach_data_byte", int'(obs_q.size() >= 3), 1);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_scl_oe", scl_oe, 0);
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rdata", rdata, 0);
        last_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        txn(1'b1, SLV, 8'h20, 8'h00);
        txn(1'b0, SLV, 8'h20, 8'h5A);
        txn(1'b1, SLV, 8'h20, 8'h00);

        for (int i = 0; i < 10; i++) begin
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 7'(7'h10 + $urandom_range(0, 15)) : SLV;
            txn(r, d, 8'($urandom_range(0, 7)), 8'($urandom));
        end

`ifdef I2C_MASTER_CLK_STRETCH_EN
        stretch_on = 1; max_low = 0;
        txn(1'b0, SLV, 8'h33, 8'hC3);
        stretch_on = 0;
        check("stretch_low_len", int'(max_low >= 40), 1);
        txn(1'b1, SLV, 8'h33, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_reg_master.md
I2C_REG_MASTER -- requirements
Module: i2c_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 63, quarter-bit period minus one in clk cycles; one SCL bit period = 4*(CLK_DIV+1) clk cycles.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  start-transaction strobe, sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have port dev_addr  input  7  target 7-bit device address.
REQ-007 SHALL have port reg_addr  input  8  target register address.
REQ-008 SHALL have port wdata  input  8  write data.
REQ-009 SHALL have port busy  output  1  high from request acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port nack  output  1  transaction aborted on missing ACK.
REQ-012 SHALL have port rdata  output  8  read data.
REQ-013 SHALL have port scl_oe  output  1  1 = pull SCL low, 0 = release.
REQ-014 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-015 SHALL have port scl_i  input  1  SCL pin level.
REQ-016 SHALL have port sda_i  input  1  SDA pin level.

Function
REQ-017 SHALL drive lines open-drain only: logic 0 via oe=1, logic 1 via oe=0; released in IDLE.
REQ-018 SHALL accept req only in IDLE; latch rw, dev_addr, reg_addr, wdata; assert busy the next cycle; ignore req while busy.
REQ-019 SHALL perform write as: START, {dev_addr,0}, ACK, reg_addr, ACK, wdata, ACK, STOP.
REQ-020 SHALL perform read as: START, {dev_addr,0}, ACK, reg_addr, ACK, repeated START, {dev_addr,1}, ACK, 8 data bits, master NACK (SDA released), STOP.
REQ-021 SHALL send bytes MSB first; change SDA only while SCL low (quarter 0); release SCL at quarter 1; sample sda_i at end of quarter 2; pull SCL low at quarter 3 end.
REQ-022 SHALL use states IDLE, START, TX_BYTE, RX_ACK, RX_BYTE, TX_NACK, RSTART, STOP, DONE.
REQ-023 START SHALL pull SDA low while SCL released, hold one half-bit, then pull SCL low.
REQ-024 STOP SHALL hold SDA low with SCL low, release SCL, wait one half-bit, release SDA, wait one half-bit.
REQ-025 On sda_i=1 at any ACK slot SHALL skip remaining bytes, go to STOP, set nack=1.
REQ-026 SHALL pulse done for exactly one cycle in DONE, then return to IDLE with busy=0 the same cycle done falls.
REQ-027 rdata and nack SHALL be valid when done pulses and hold until next request acceptance; acceptance clears nack.
REQ-028 rdata SHALL remain unchanged on write transactions and on aborted reads.
REQ-029 Bit counter SHALL be 3 bits, wrap 7->0 ending each byte; quarter counter SHALL count 0..CLK_DIV.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, rdata=8'h00, counters zero.
REQ-031 Reset mid-transaction SHALL abandon the transfer without generating STOP; first req after release starts a fresh transaction.

Configuration
REQ-032 Macro I2C_MASTER_CLK_STRETCH_EN defined: scl_i synchronised through two flops; after releasing SCL the quarter counter SHALL hold until synchronised scl_i reads 1 (target clock stretching honoured).
REQ-033 Macro undefined: scl_i SHALL be unused and all timing purely counter-driven.

Verification (CLK_DIV=3, 16 clk per bit)
REQ-034 Write dev 0x42, reg 0x05, data 0xA5, slave ACKs all -> bus shows 0x84,0x05,0xA5 each ACKed, STOP, done pulse, nack=0, busy low after done.
REQ-035 Read dev 0x42, reg 0x03, slave returns 0x3C -> bytes 0x84,0x03, Sr, 0x85, data 0x3C, master NACK, STOP; rdata=0x3C at done.
REQ-036 Write to dev 0x11 with no slave (SDA pulled up) -> NACK after first byte, immediate STOP, done with nack=1, reg_addr never sent.
REQ-037 Second req pulse asserted mid-transfer -> ignored; exactly one transaction on bus; next req after done accepted.
REQ-038 rst_n low during data byte -> scl_oe=sda_oe=0 same cycle, busy=0; subsequent write completes normally.
REQ-039 With I2C_MASTER_CLK_STRETCH_EN, slave holds SCL low 40 clk after ACK -> next bit's high phase starts only after release; data still correct.
